// File: rtl/des_sbox_sequencer_if.sv
// Bus bundle for des_sbox_sequencer.
//   in_*   : upstream 48-bit word handshake (valid/ready)
//   sbox_* : shared combinational S-box lookup port (sel/addr out, data back)
//   out_*  : downstream 32-bit result handshake (valid/ready)
// slave  : the sequencer's view; master : the surrounding datapath's view.
interface des_sbox_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic [3:0]  sbox_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport slave (
    input  in_valid, in_data, sbox_data, out_ready,
    output in_ready, sbox_sel, sbox_addr, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, sbox_data, out_ready,
    input  in_ready, sbox_sel, sbox_addr, out_valid, out_data
  );
endinterface

// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer
// Walks one shared DES S-box lookup port across the eight S-box positions of
// the f-function substitution stage. A 48-bit key-mixed word is accepted,
// presented as eight 6-bit chunks (S1 first) over eight cycles, and the
// returned nibbles are assembled into a 32-bit result (S1 in [31:28]).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   flush   : synchronous abort back to IDLE, highest priority
//   bus     : slave side of des_sbox_sequencer_if (in/sbox/out handshakes)
//   busy    : high while in LOOKUP or DONE
module des_sbox_sequencer (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  des_sbox_sequencer_if.slave         bus,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [47:0] hold_q, hold_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] result_q, result_d;

  logic        in_ready;
  logic        out_valid;
  logic [2:0]  sbox_sel;
  logic [5:0]  sbox_addr;
  logic        accept;
  logic [5:0]  chunk_lsb;
  logic [4:0]  nib_lsb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    idx_d     = idx_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sbox_sel  = '0;
    sbox_addr = '0;
    accept    = 1'b0;
    // S(idx+1) chunk sits at hold[47-6*idx -: 6]; its nibble at result[31-4*idx -: 4]
    chunk_lsb = 6'd42 - ({3'b000, idx_q} * 6'd6);
    nib_lsb   = 5'd28 - {idx_q, 2'b00};

    case (state_q)
      IDLE: begin
        in_ready = !flush;
      end
      LOOKUP: begin
        sbox_sel  = idx_q;
        sbox_addr = hold_q[chunk_lsb +: 6];
        result_d[nib_lsb +: 4] = bus.sbox_data;
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // never advertise ready into DONE unless the result leaves this edge
        in_ready  = bus.out_ready && !flush;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = bus.in_valid && in_ready;
    if (accept) begin
      hold_d   = bus.in_data;
      idx_d    = '0;
      result_d = '0;
      state_d  = LOOKUP;
    end

    if (flush) begin
      state_d  = IDLE;
      idx_d    = '0;
      result_d = '0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = result_q;
  assign bus.sbox_sel  = sbox_sel;
  assign bus.sbox_addr = sbox_addr;
  assign busy          = (state_q == LOOKUP) || (state_q == DONE);

endmodule
